// File: rtl/key_debounce_multi_if.sv
// key_debounce_multi_if: raw key pins toward the debouncer, debounced levels and event pulses back
// Signals: key_in (raw pins), key_out (debounced level), key_press / key_release / key_long (1-cycle pulses),
// key_busy (channel window active). master = pin/consumer side, slave = debouncer.
interface key_debounce_multi_if #(
    parameter int NUM_KEYS = 4
);
    logic [NUM_KEYS-1:0] key_in;
    logic [NUM_KEYS-1:0] key_out;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;
    logic [NUM_KEYS-1:0] key_long;
    logic [NUM_KEYS-1:0] key_busy;
    modport master (output key_in, input key_out, key_press, key_release, key_long, key_busy);
    modport slave (input key_in, output key_out, key_press, key_release, key_long, key_busy);
endinterface

// File: rtl/key_debounce_multi.sv
// key_debounce_multi: per-channel synchroniser plus lock-out (MODE 0) or stable-confirm (MODE 1) debouncer
// Ports: clk, nrst (async active-low), bus (slave modport): key_in raw pins in; key_out debounced level,
// key_press / key_release / key_long 1-cycle pulses and key_busy window flag out, one bit per channel.
module key_debounce_multi #(
    parameter int NUM_KEYS    = 4,
    parameter int DEB_CYCLES  = 1_000_000,
    parameter int LONG_CYCLES = 50_000_000,
    parameter int SYNC_STAGES = 2,
    parameter bit MODE        = 1'b1,
    parameter bit PRESS_LEVEL = 1'b0
) (
    input logic clk,
    input logic nrst,
    key_debounce_multi_if.slave bus
);
    localparam int DW = $clog2(DEB_CYCLES);
    // LC keeps the hold counter at least one bit wide when long-press is disabled
    localparam int LC = (LONG_CYCLES > 0) ? LONG_CYCLES : 1;
    localparam int HW = $clog2(LC + 1);
    localparam logic REL = !PRESS_LEVEL;
    // COUNT is the confirm window in MODE 1 and the lock-out window in MODE 0
    typedef enum logic {STABLE, COUNT} state_t;
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync;
        logic key_sync, upd;
        logic out_r, press_r, rel_r, long_r, busy_r;
        logic [DW-1:0] cnt;
        logic [HW-1:0] hold;
        state_t state;
        assign key_sync = sync[SYNC_STAGES-1];
        // lock-out takes a differing sample at once; confirm takes it at the end of a full window
        assign upd = (key_sync != out_r) &&
                     (MODE ? (state == COUNT && cnt == DW'(DEB_CYCLES - 1)) : (state == STABLE));
        always_ff @(posedge clk or negedge nrst)
            if (!nrst) begin
                sync    <= {SYNC_STAGES{REL}};
                state   <= STABLE;
                cnt     <= '0;
                hold    <= '0;
                out_r   <= REL;
                press_r <= 1'b0;
                rel_r   <= 1'b0;
                long_r  <= 1'b0;
                busy_r  <= 1'b0;
            end else begin
                sync    <= {sync[SYNC_STAGES-2:0], bus.key_in[i]};
                out_r   <= upd ? key_sync : out_r;
                press_r <= upd && key_sync == PRESS_LEVEL;
                rel_r   <= upd && key_sync != PRESS_LEVEL;
                long_r  <= (LONG_CYCLES != 0) && !upd && out_r == PRESS_LEVEL && hold == HW'(LC - 1);
                // hold restarts on every key_out change, saturates so key_long never repeats
                hold    <= (upd || out_r != PRESS_LEVEL) ? '0 : (hold == HW'(LC) ? hold : hold + 1'b1);
                if (state == STABLE) begin
                    cnt    <= '0;
                    state  <= (key_sync != out_r) ? COUNT : STABLE;
                    busy_r <= key_sync != out_r;
                end else if ((MODE && key_sync == out_r) || cnt == DW'(DEB_CYCLES - 1)) begin
                    cnt    <= '0;
                    state  <= STABLE;
                    busy_r <= 1'b0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        assign bus.key_out[i]     = out_r;
        assign bus.key_press[i]   = press_r;
        assign bus.key_release[i] = rel_r;
        assign bus.key_long[i]    = long_r;
        assign bus.key_busy[i]    = busy_r;
    end
endmodule

// File: tb/tb_key_debounce_multi.sv
// tb_key_debounce_multi: drives a confirm-mode and a lock-out-mode debouncer with the same pins against a run-length model
module tb_key_debounce_multi;
    localparam int N = 4, DEB = 8, LONG = 40;
    logic clk = 1'b0;
    logic nrst = 1'b1;
    logic [N-1:0] kin = '1;
    int tests = 0, fails = 0;
    key_debounce_multi_if #(.NUM_KEYS(N)) bus1 ();
    key_debounce_multi_if #(.NUM_KEYS(N)) bus0 ();
    assign bus1.key_in = kin;
    assign bus0.key_in = kin;
    key_debounce_multi #(.NUM_KEYS(N), .DEB_CYCLES(DEB), .LONG_CYCLES(LONG), .SYNC_STAGES(2),
                         .MODE(1'b1), .PRESS_LEVEL(1'b0)) dut1 (.clk(clk), .nrst(nrst), .bus(bus1));
    key_debounce_multi #(.NUM_KEYS(N), .DEB_CYCLES(DEB), .LONG_CYCLES(LONG), .SYNC_STAGES(2),
                         .MODE(1'b0), .PRESS_LEVEL(1'b0)) dut0 (.clk(clk), .nrst(nrst), .bus(bus0));
    always #5 clk = ~clk;
    logic [19:0] d1, d0;
    assign d1 = {bus1.key_out, bus1.key_press, bus1.key_release, bus1.key_long, bus1.key_busy};
    assign d0 = {bus0.key_out, bus0.key_press, bus0.key_release, bus0.key_long, bus0.key_busy};
    // Model: index 1 = confirm, index 0 = lock-out
    logic [N-1:0] m_out[2], m_pr[2], m_rl[2], m_lg[2], m_bz[2];
    int run[N], since[N], held[2][N];
    logic [N-1:0] q[$];
    function automatic logic [19:0] exp_vec(input int m);
        return {m_out[m], m_pr[m], m_rl[m], m_lg[m], m_bz[m]};
    endfunction
    task automatic model_reset();
        q.delete();
        q.push_back('1);
        q.push_back('1);
        for (int m = 0; m < 2; m++) begin
            m_out[m] = '1;
            m_pr[m] = '0;
            m_rl[m] = '0;
            m_lg[m] = '0;
            m_bz[m] = '0;
            for (int i = 0; i < N; i++) held[m][i] = 0;
        end
        for (int i = 0; i < N; i++) begin
            run[i] = 0;
            since[i] = 1000;
        end
    endtask
    // Confirm: accept once the synced level has differed for DEB+1 consecutive samples.
    // Lock-out: accept a differing sample if the last change was more than DEB edges ago.
    task automatic model_edge();
        logic [N-1:0] ks;
        logic chg;
        if (!nrst) begin
            model_reset();
            return;
        end
        ks = q.pop_front();
        q.push_back(kin);
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < N; i++) begin
                if (m == 1) begin
                    run[i] = (ks[i] != m_out[1][i]) ? run[i] + 1 : 0;
                    chg = run[i] == DEB + 1;
                    if (chg) run[i] = 0;
                    m_bz[1][i] = run[i] > 0;
                end else begin
                    if (since[i] < 1000) since[i]++;
                    chg = ks[i] != m_out[0][i] && since[i] > DEB;
                    if (chg) since[i] = 0;
                    m_bz[0][i] = since[i] < DEB;
                end
                m_pr[m][i] = chg && !ks[i];
                m_rl[m][i] = chg && ks[i];
                if (chg) begin
                    m_out[m][i] = ks[i];
                    held[m][i] = 0;
                end else if (!m_out[m][i] && held[m][i] < 1000) held[m][i]++;
                m_lg[m][i] = !chg && !m_out[m][i] && held[m][i] == LONG;
            end
    endtask
    task automatic step(input logic [N-1:0] k);
        kin = k;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask
    task automatic apply_reset();
        nrst = 1'b0;
        model_reset();
        step(kin);
        step(kin);
        nrst = 1'b1;
    endtask
    task automatic test_reset();
        kin = '1;
        #1 nrst = 1'b0;
        model_reset();
        #1;
        tests++;
        if (d1 !== 20'hF0000) begin
            fails++;
            $display("FAIL reset_confirm: dut=%h want=%h", d1, 20'hF0000);
        end
        tests++;
        if (d0 !== 20'hF0000) begin
            fails++;
            $display("FAIL reset_lockout: dut=%h want=%h", d0, 20'hF0000);
        end
        @(negedge clk);
        apply_reset();
    endtask
    task automatic test_confirm_latency();
        int fall = -1, np = 0, nb = 0;
        apply_reset();
        for (int s = 1; s <= 40; s++) begin
            step(s <= 25 ? 4'hE : 4'hF);
            tests++;
            if ({d1, d0} !== {exp_vec(1), exp_vec(0)}) begin
                fails++;
                $display("FAIL confirm cyc %0d: dut=%h model=%h", s, {d1, d0}, {exp_vec(1), exp_vec(0)});
            end
            if (fall < 0 && !bus1.key_out[0]) fall = s;
            if (s <= 25) np += int'(bus1.key_press[0]);
            if (s <= 25) nb += int'(bus1.key_busy[0]);
        end
        tests++;
        if (fall !== 11) begin fails++; $display("FAIL confirm_latency: got %0d want 11", fall); end
        tests++;
        if (np !== 1) begin fails++; $display("FAIL confirm_press_count: got %0d want 1", np); end
        tests++;
        if (nb !== 8) begin fails++; $display("FAIL confirm_busy_cycles: got %0d want 8", nb); end
    endtask
    task automatic test_bounce();
        int fall = -1, np = 0, nr = 0;
        apply_reset();
        for (int s = 1; s <= 35; s++) begin
            step((s <= 5 || s >= 8) ? 4'hD : 4'hF);
            tests++;
            if ({d1, d0} !== {exp_vec(1), exp_vec(0)}) begin
                fails++;
                $display("FAIL bounce cyc %0d: dut=%h model=%h", s, {d1, d0}, {exp_vec(1), exp_vec(0)});
            end
            if (fall < 0 && !bus1.key_out[1]) fall = s;
            np += int'(bus1.key_press[1]);
            nr += int'(bus1.key_release[1]);
        end
        tests++;
        if (fall !== 18) begin fails++; $display("FAIL bounce_fall: got %0d want 18", fall); end
        tests++;
        if (np !== 1 || nr !== 0) begin
            fails++;
            $display("FAIL bounce_pulses: press=%0d release=%0d want 1 0", np, nr);
        end
    endtask
    task automatic test_lockout();
        int fall = -1, rise = -1, np = 0, nr = 0;
        logic [6:0] pat = 7'b1010100;
        apply_reset();
        for (int s = 1; s <= 30; s++) begin
            step({1'b1, (s <= 7) ? pat[s-1] : 1'b1, 2'b11});
            tests++;
            if ({d1, d0} !== {exp_vec(1), exp_vec(0)}) begin
                fails++;
                $display("FAIL lockout cyc %0d: dut=%h model=%h", s, {d1, d0}, {exp_vec(1), exp_vec(0)});
            end
            if (fall < 0 && !bus0.key_out[2]) fall = s;
            if (fall > 0 && rise < 0 && bus0.key_out[2]) rise = s;
            np += int'(bus0.key_press[2]);
            nr += int'(bus0.key_release[2]);
        end
        tests++;
        if (fall !== 3) begin fails++; $display("FAIL lockout_fall: got %0d want 3", fall); end
        tests++;
        if (rise !== 12) begin fails++; $display("FAIL lockout_rise: got %0d want 12", rise); end
        tests++;
        if (np !== 1 || nr !== 1) begin
            fails++;
            $display("FAIL lockout_pulses: press=%0d release=%0d want 1 1", np, nr);
        end
    endtask
    task automatic test_long_press();
        int pr[$], lg[$];
        int nr = 0;
        apply_reset();
        for (int s = 1; s <= 170; s++) begin
            step((s <= 60 || (s > 90 && s <= 150)) ? 4'h7 : 4'hF);
            tests++;
            if ({d1, d0} !== {exp_vec(1), exp_vec(0)}) begin
                fails++;
                $display("FAIL long cyc %0d: dut=%h model=%h", s, {d1, d0}, {exp_vec(1), exp_vec(0)});
            end
            if (bus1.key_press[3]) pr.push_back(s);
            if (bus1.key_long[3]) lg.push_back(s);
            nr += int'(bus1.key_release[3]);
        end
        tests++;
        if (pr.size() != 2 || lg.size() != 2 || nr != 2) begin
            fails++;
            $display("FAIL long_counts: press=%0d long=%0d release=%0d want 2 2 2", pr.size(), lg.size(), nr);
        end else begin
            tests++;
            if (lg[0] - pr[0] !== 40) begin fails++; $display("FAIL long_delay1: got %0d want 40", lg[0] - pr[0]); end
            tests++;
            if (lg[1] - pr[1] !== 40) begin fails++; $display("FAIL long_delay2: got %0d want 40", lg[1] - pr[1]); end
        end
    endtask
    task automatic test_multi();
        int rel_at[N];
        int npc = 0;
        logic [N-1:0] pv = '0;
        apply_reset();
        for (int i = 0; i < N; i++) rel_at[i] = -1;
        for (int s = 1; s <= 45; s++) begin
            step({s > 30, s > 20, s > 25, s > 20});
            tests++;
            if ({d1, d0} !== {exp_vec(1), exp_vec(0)}) begin
                fails++;
                $display("FAIL multi cyc %0d: dut=%h model=%h", s, {d1, d0}, {exp_vec(1), exp_vec(0)});
            end
            if (|bus1.key_press) begin
                npc++;
                pv = bus1.key_press;
            end
            for (int i = 0; i < N; i++) if (bus1.key_release[i]) rel_at[i] = s;
        end
        tests++;
        if (npc !== 1 || pv !== 4'hF) begin
            fails++;
            $display("FAIL multi_press: cycles=%0d vec=%h want 1 f", npc, pv);
        end
        tests++;
        if (rel_at[0] !== 31 || rel_at[1] !== 36 || rel_at[2] !== 31 || rel_at[3] !== 41) begin
            fails++;
            $display("FAIL multi_release: at %0d %0d %0d %0d want 31 36 31 41", rel_at[0], rel_at[1], rel_at[2], rel_at[3]);
        end
    endtask
    task automatic test_reset_mid_confirm();
        int fall = -1, np = 0;
        apply_reset();
        for (int s = 1; s <= 8; s++) step(4'h0);
        tests++;
        if (bus1.key_busy !== 4'hF || bus1.key_out !== 4'hF) begin
            fails++;
            $display("FAIL midreset_pre: busy=%h out=%h want f f", bus1.key_busy, bus1.key_out);
        end
        nrst = 1'b0;
        model_reset();
        #1;
        tests++;
        if ({d1, d0} !== {20'hF0000, 20'hF0000}) begin
            fails++;
            $display("FAIL midreset_async: dut=%h want=%h", {d1, d0}, {20'hF0000, 20'hF0000});
        end
        @(negedge clk);
        step(4'h0);
        nrst = 1'b1;
        for (int s = 1; s <= 20; s++) begin
            step(4'h0);
            tests++;
            if ({d1, d0} !== {exp_vec(1), exp_vec(0)}) begin
                fails++;
                $display("FAIL midreset cyc %0d: dut=%h model=%h", s, {d1, d0}, {exp_vec(1), exp_vec(0)});
            end
            if (fall < 0 && !bus1.key_out[0]) fall = s;
            np += int'(bus1.key_press[0]);
        end
        tests++;
        if (fall !== 11 || np !== 1) begin
            fails++;
            $display("FAIL midreset_repress: fall=%0d press=%0d want 11 1", fall, np);
        end
    endtask
    task automatic test_random();
        logic [N-1:0] k = '1;
        int p = 10;
        apply_reset();
        for (int s = 1; s <= 4000; s++) begin
            if (s % 200 == 1) p = (s % 600 == 1) ? 3 : ((s % 600 == 201) ? 12 : 70);
            for (int i = 0; i < N; i++) if ($urandom_range(0, p - 1) == 0) k[i] = ~k[i];
            if (s == 2000) apply_reset();
            step(k);
            tests++;
            if ({d1, d0} !== {exp_vec(1), exp_vec(0)}) begin
                fails++;
                $display("FAIL random cyc %0d: dut=%h model=%h", s, {d1, d0}, {exp_vec(1), exp_vec(0)});
            end
        end
    endtask
    initial begin
        model_reset();
        test_reset();
        test_confirm_latency();
        test_bounce();
        test_lockout();
        test_long_press();
        test_multi();
        test_reset_mid_confirm();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/key_debounce_multi.md
Name: key_debounce_multi

Overview:
Multi-channel, parametrised key debouncer. It is the next generation of the team's single-key debouncer. Each channel synchronises a raw mechanical key input and filters it with a selectable algorithm: lock-out (gen-1 behaviour) or stable-confirm. It emits a debounced level plus one-cycle press, release and long-press pulses. It sits between board pins and the LED/mode-control logic.

Parameters:
NUM_KEYS, 4, number of independent key channels
DEB_CYCLES, 1_000_000, debounce window in clk cycles (20 ms at 50 MHz); legal range 2..2^24
LONG_CYCLES, 50_000_000, hold time for long-press pulse, counted from press edge; 0 = long-press disabled
SYNC_STAGES, 2, input synchroniser depth; legal range 2..4
MODE, 1, 0 = lock-out (accept change immediately, then ignore input for DEB_CYCLES); 1 = confirm (accept change only after DEB_CYCLES of stable differing input)
PRESS_LEVEL, 0, key_out level meaning "pressed" (0 = active-low buttons)

Ports:
clk  in  1  system clock
nrst  in  1  asynchronous active-low reset
key_in  in  NUM_KEYS  raw asynchronous key pins
key_out  out  NUM_KEYS  debounced key level
key_press  out  NUM_KEYS  1-cycle pulse when key_out changes to PRESS_LEVEL
key_release  out  NUM_KEYS  1-cycle pulse when key_out leaves PRESS_LEVEL
key_long  out  NUM_KEYS  1-cycle pulse after LONG_CYCLES continuous press
key_busy  out  NUM_KEYS  channel is counting (lock-out or confirm window active)

Behaviour:
- Reset is asynchronous and active-low; clk is the clock. Every register is cleared or preset on nrst low.
- Reset values: synchroniser flops = ~PRESS_LEVEL; key_out = ~PRESS_LEVEL (released); key_press, key_release, key_long, key_busy = 0; all counters = 0.
- Synchroniser: key_in[i] passes through SYNC_STAGES flops to give key_sync[i]. All further logic uses key_sync only.
- Channels are fully independent. There is one debounce counter per channel, width $clog2(DEB_CYCLES), and one hold counter, width $clog2(LONG_CYCLES+1).
- MODE 1, states STABLE / CONFIRM:
  - STABLE: if key_sync != key_out, go to CONFIRM with cnt = 0.
  - CONFIRM: cnt increments each cycle.
  - If key_sync == key_out in any cycle, return to STABLE, cnt = 0, key_out is unchanged (glitch rejected).
  - If cnt == DEB_CYCLES-1 and key_sync != key_out, key_out <= key_sync, go to STABLE, cnt = 0.
  - Net: key_out updates exactly DEB_CYCLES+1 cycles after the first differing key_sync sample, provided key_sync stays stable.
- MODE 0, states STABLE / LOCK:
  - STABLE: if key_sync != key_out, key_out <= key_sync on the same edge, go to LOCK with cnt = 0.
  - LOCK: cnt increments and key_sync is ignored.
  - At cnt == DEB_CYCLES-1, return to STABLE. If key_sync still differs from key_out in the next STABLE cycle, it is taken immediately.
- key_busy[i] = 1 while the channel is in CONFIRM or LOCK.
- Pulses are registered and asserted in the first cycle key_out shows its new value: key_press when the new value == PRESS_LEVEL, key_release otherwise. Pulses are exactly one cycle wide.
- Long press:
  - The hold counter is cleared on the press edge and increments each cycle key_out == PRESS_LEVEL.
  - key_long pulses once in the cycle the counter reaches LONG_CYCLES, then the counter saturates (no repeat).
  - Release clears the counter.
  - If LONG_CYCLES = 0, key_long is tied to 0.
- Simultaneous events: the channels never interact; all channels may pulse in the same cycle.
- Reset mid-count: all state returns to reset values immediately. No pulses are generated on reset deassertion, even if key_in is held at PRESS_LEVEL; that press is debounced normally afterwards.
- Counters never wrap: the debounce counter is always cleared at DEB_CYCLES-1, and the hold counter saturates.

Test Plan:
(All cases use NUM_KEYS=4, DEB_CYCLES=8, LONG_CYCLES=40, SYNC_STAGES=2, PRESS_LEVEL=0.)
1. MODE=1: key_in[0] 1->0 held steady -> key_out[0] falls 11 cycles after the input edge (2 sync + 9); key_press[0] high for exactly 1 cycle, aligned with the fall; key_busy[0] high for 8 cycles.
2. MODE=1 bounce: key_in[1] toggles low 5 cycles, high 2, low 20 -> key_out[1] falls only after the final 8-cycle stable window; exactly one key_press; no key_release.
3. MODE=0: key_in[2] 1->0 then bounces for 6 cycles -> key_out[2] falls 3 cycles after the edge and stays low; a change back to 1 arriving during lock is taken on the first STABLE cycle after the 8-cycle lock.
4. Long press: hold key_in[3] low 60 cycles -> key_long[3] pulses once, 40 cycles after key_press[3]; no further pulses. Release -> one key_release[3]. Re-press -> key_long fires again after 40 cycles.
5. Multi-channel: all four keys pressed on the same cycle -> all four key_press pulses occur on the same cycle; independent releases produce independent key_release pulses.
6. Reset mid-confirm: assert nrst at cnt = 5 with key_in held 0 -> outputs immediately read key_out = 4'hF with pulses = 0; after release, key_out falls 11 cycles later with one key_press.
